noc_input_port: RTL and testbench
=================================

// Module: noc_input_port
// PURPOSE
//  Router input port directly upstream of the YX route computation stage. Buffers incoming flits.
//  Presents each head flit's 8-bit destination to the YX route computation stage and latches the returned 3-bit route.
//  Requests the switch allocator and streams the packet (wormhole) to the crossbar until the tail flit.
//  One instance per router input direction.
// PARAMETERS
//  FLIT_W  34  flit width: [33:32] type, [31:0] payload; head payload[7:0] = dest {x[7:4],y[3:0]}
//  DEPTH   4   input FIFO entries (power of 2, >=2)
// PORTS
//  clk_i        in   1       clock, all state on rising edge
//  rst_ni       in   1       asynchronous active-low reset
//  in_valid_i   in   1       upstream flit valid
//  in_ready_o   out  1       port can accept a flit (= !fifo_full)
//  in_flit_i    in   FLIT_W  upstream flit
//  hdr_addr_o   out  8       dest address to YX route computation stage (yx_addr_header_i)
//  route_i      in   3       route from YX route computation stage: 000 Y-,001 Y+,010 X-,011 X+,100 LOCAL
//  sw_req_o     out  1       switch allocation request, held for the whole packet
//  sw_route_o   out  3       requested output port (latched route)
//  sw_gnt_i     in   1       allocator grant
//  out_valid_o  out  1       flit to crossbar valid
//  out_ready_i  in   1       crossbar/downstream ready
//  out_flit_o   out  FLIT_W  flit to crossbar
//  err_o        out  1       1-cycle pulse: orphan BODY/TAIL flit dropped
//  pkt_cnt_o    out  16      completed packet count (see CONFIGURATION)
// BEHAVIOUR
//  Reset values:
//   - in_ready_o=1; all other outputs 0.
//   - FIFO empty, FSM IDLE, route_q=0.
//  Flit types: 00 BODY, 01 HEAD, 10 TAIL, 11 HEAD_TAIL.
//  FIFO:
//   - push on in_valid_i&&in_ready_o.
//   - pop on out_valid_o&&out_ready_i, or on an orphan drop.
//   - Push and pop in the same cycle are both legal when not full.
//   - When full, in_ready_o=0 even if a pop occurs that cycle (ready has no pop dependency).
//   - Pointers wrap modulo DEPTH; a separate count distinguishes full from empty.
//  FSM (hdr_addr_o = fifo head payload[7:0] in every state):
//   - IDLE:
//     - FIFO empty -> stay.
//     - Head is HEAD/HEAD_TAIL -> ROUTE.
//     - Head is BODY/TAIL -> pop it, pulse err_o, stay in IDLE.
//   - ROUTE (1 cycle): route_q<=route_i -> REQ.
//   - REQ:
//     - sw_req_o=1, sw_route_o=route_q; wait for sw_gnt_i.
//     - When sw_gnt_i=1 -> XFER (no flit moves in the grant cycle).
//   - XFER:
//     - sw_req_o stays 1; out_valid_o=!fifo_empty; out_flit_o=head.
//     - Popping a TAIL/HEAD_TAIL flit -> IDLE; sw_req_o=0 from the next cycle.
//     - A HEAD inside a packet is forwarded as data (no re-route).
//  Latency:
//   - Header accepted at cycle t: ROUTE at t+2, REQ at t+3.
//   - With sw_gnt_i high, first out_valid_o at t+4.
//   - Afterwards 1 flit/cycle under no backpressure.
//  out_valid_o is never deasserted while out_ready_i=0 and flit data stays stable (standard valid/ready).
//  Reset mid-operation: FIFO is flushed and FSM goes to IDLE. The partial packet is lost, err_o stays 0, and pkt_cnt_o is cleared.
//  Empty FIFO mid-XFER: out_valid_o=0, sw_req_o is held, FSM remains in XFER.
// CONFIGURATION
//  Macro NOC_INPUT_PORT_STATS_EN:
//   - Defined: pkt_cnt_o increments on every tail pop, saturating at 16'hFFFF.
//   - Undefined: no counter is built and pkt_cnt_o is tied to 0.
// STRUCTURE
//  Package noc_pkg:
//   - FLIT_W.
//   - flit_type_e {BODY,HEAD,TAIL,HEAD_TAIL}.
//   - route_e {Y_MINUS,Y_PLUS,X_MINUS,X_PLUS,LOCAL}.
//   - ip_state_e {IDLE,ROUTE,REQ,XFER}.
//  Sub-module noc_ip_fifo: synchronous FIFO with parameters FLIT_W and DEPTH, and ports push, pop, full, empty, head.
//  FSM, route latch and stats counter live in noc_input_port.
// TESTING
//  1. HEAD_TAIL dest 8'h23, model route_i=001, sw_gnt_i=1 -> sw_route_o=001; flit on out at t+4; pkt_cnt_o=1 (macro on).
//  2. HEAD+2 BODY+TAIL, out_ready_i toggling 1010.. -> 4 flits in order, data stable while stalled, sw_req_o high until cycle after tail.
//  3. DEPTH=4, out_ready_i=0, 6 flits offered -> in_ready_o=0 after 4th push; after release all 6 delivered, none lost.
//  4. BODY flit arrives in IDLE -> dropped, err_o high exactly 1 cycle, no sw_req_o.
//  5. rst_ni low mid-XFER of 4-flit packet -> all outputs 0, in_ready_o=1, FIFO empty; next packet routed normally.
//  6. sw_gnt_i withheld 10 cycles -> sw_req_o held, no out_valid_o; flow starts cycle after grant.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types for the router input port: flit encoding, route codes and port FSM states.
package noc_pkg;

  localparam int FLIT_W = 34;

  typedef enum logic [1:0] {
    BODY      = 2'b00,
    HEAD      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    Y_MINUS = 3'd0,
    Y_PLUS  = 3'd1,
    X_MINUS = 3'd2,
    X_PLUS  = 3'd3,
    LOCAL   = 3'd4
  } route_e;

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    REQ,
    XFER
  } ip_state_e;

  function automatic logic starts_pkt(input flit_type_e t);
    return (t == HEAD) || (t == HEAD_TAIL);
  endfunction

  function automatic logic ends_pkt(input flit_type_e t);
    return (t == TAIL) || (t == HEAD_TAIL);
  endfunction

endpackage

// File: rtl/noc_ip_fifo.sv
// Input flit buffer: registered storage, head visible the cycle after push; push ignored when full.
// Ready has no pop dependency, so a full FIFO refuses a push even in a cycle where it pops.
module noc_ip_fifo #(
  parameter int FLIT_W = 34,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [FLIT_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [FLIT_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [FLIT_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head (and thus every port output) reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_input_port.sv
// Router input port: buffers flits, routes each head via the YX stage, then streams the packet after switch grant.
// Head accepted at t is first offered at t+4 with grant; valid/ready on both sides. Stats counter: NOC_INPUT_PORT_STATS_EN.
module noc_input_port #(
  parameter int FLIT_W = noc_pkg::FLIT_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [FLIT_W-1:0] in_flit_i,
  output logic [7:0]        hdr_addr_o,
  input  logic [2:0]        route_i,
  output logic              sw_req_o,
  output logic [2:0]        sw_route_o,
  input  logic              sw_gnt_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [FLIT_W-1:0] out_flit_o,
  output logic              err_o,
  output logic [15:0]       pkt_cnt_o
);

  import noc_pkg::*;

  ip_state_e         state;
  route_e            route_q;
  logic              sw_req_q;
  logic              err_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [FLIT_W-1:0] fifo_head;
  logic              fifo_pop;
  flit_type_e        head_type;
  logic              orphan_drop;
  logic              xfer_pop;
  logic              tail_pop;

  noc_ip_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (in_valid_i),
    .din   (in_flit_i),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign head_type   = flit_type_e'(fifo_head[FLIT_W-1:FLIT_W-2]);
  assign orphan_drop = (state == IDLE) && !fifo_empty && !starts_pkt(head_type);
  assign out_valid_o = (state == XFER) && !fifo_empty;
  assign xfer_pop    = out_valid_o && out_ready_i;
  assign tail_pop    = xfer_pop && ends_pkt(head_type);
  assign fifo_pop    = xfer_pop || orphan_drop;

  assign in_ready_o  = !fifo_full;
  assign hdr_addr_o  = fifo_head[7:0];
  assign out_flit_o  = fifo_head;
  assign sw_req_o    = sw_req_q;
  assign sw_route_o  = route_q;
  assign err_o       = err_q;

  // A HEAD seen while in XFER is just payload; only the tail pop returns to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      route_q  <= Y_MINUS;
      sw_req_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= orphan_drop;
      case (state)
        IDLE: begin
          if (!fifo_empty && starts_pkt(head_type)) begin
            state <= ROUTE;
          end
        end
        ROUTE: begin
          route_q  <= route_e'(route_i);
          sw_req_q <= 1'b1;
          state    <= REQ;
        end
        REQ: begin
          if (sw_gnt_i) begin
            state <= XFER;
          end
        end
        XFER: begin
          if (tail_pop) begin
            sw_req_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          sw_req_q <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef NOC_INPUT_PORT_STATS_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_cnt_q <= '0;
    end else if (tail_pop && (pkt_cnt_q != 16'hFFFF)) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
`else
  assign pkt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// Directed bench for noc_input_port; the YX route stage is modelled for a router at x=2, y=2.
module tb_noc_input_port;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] in_flit;
  logic [7:0]  hdr_addr;
  logic [2:0]  route;
  logic        sw_req;
  logic [2:0]  sw_route;
  logic        sw_gnt;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_flit;
  logic        err;
  logic [15:0] pkt_cnt;

  int nvec = 0;
  int nerr = 0;
  logic [33:0] pkt [8];

  noc_input_port #(.FLIT_W(34), .DEPTH(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_flit_i   (in_flit),
    .hdr_addr_o  (hdr_addr),
    .route_i     (route),
    .sw_req_o    (sw_req),
    .sw_route_o  (sw_route),
    .sw_gnt_i    (sw_gnt),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_flit_o  (out_flit),
    .err_o       (err),
    .pkt_cnt_o   (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    route = 3'b100;
    if (hdr_addr[3:0] > 4'd2)      route = 3'b001;
    else if (hdr_addr[3:0] < 4'd2) route = 3'b000;
    else if (hdr_addr[7:4] > 4'd2) route = 3'b011;
    else if (hdr_addr[7:4] < 4'd2) route = 3'b010;
  end

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] mk(input logic [1:0] t, input logic [31:0] p);
    return {t, p};
  endfunction

  function automatic logic [15:0] expc(input int k);
`ifdef NOC_INPUT_PORT_STATS_EN
    return 16'(k);
`else
    return 16'(k * 0);
`endif
  endfunction

  // Drives pkt[0..n-1] in and checks them out; out_ready held low for `hold` cycles, then 1 or toggling.
  task automatic run(input string tag, input int n, input logic [2:0] exp_route,
                     input int hold, input bit tog, input bit chk_full);
    int scnt = 0;
    int dcnt = 0;
    int cyc = 0;
    bit pstall = 0;
    bit route_seen = 0;
    bit tail_pend = 0;
    bit done = 0;
    logic [33:0] pflit = '0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (tail_pend) begin
        chk({tag, "_req_after_tail"}, 34'(sw_req), 34'(0));
        done = 1;
      end
      if (sw_req && !route_seen) begin
        route_seen = 1;
        chk({tag, "_route"}, 34'(sw_route), 34'(exp_route));
      end
      if (pstall) begin
        chk({tag, "_stall_vld"}, 34'(out_valid), 34'(1));
        chk({tag, "_stall_dat"}, out_flit, pflit);
      end
      if (chk_full && cyc == hold) begin
        chk({tag, "_full_rdy"}, 34'(in_ready), 34'(0));
        chk({tag, "_full_pushes"}, 34'(scnt), 34'(4));
      end
      out_ready = (cyc > hold) && (tog ? cyc[0] : 1'b1);
      if (out_valid && out_ready && !tail_pend) begin
        chk({tag, "_dat"}, out_flit, pkt[dcnt]);
        dcnt++;
        if (dcnt == n) begin
          chk({tag, "_req_at_tail"}, 34'(sw_req), 34'(1));
          tail_pend = 1;
        end
      end
      pstall = out_valid && !out_ready;
      pflit  = out_flit;
      if (scnt < n) begin
        in_valid = 1'b1;
        in_flit  = pkt[scnt];
        if (in_ready) scnt++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk({tag, "_delivered"}, 34'(dcnt), 34'(n));
  endtask

  initial begin
    int k;
    rst_n = 1'b0; in_valid = 1'b0; in_flit = '0; sw_gnt = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 34'(in_ready), 34'(1));
    chk("rst_sw_req", 34'(sw_req), 34'(0));
    chk("rst_out_valid", 34'(out_valid), 34'(0));
    chk("rst_out_flit", out_flit, 34'(0));
    chk("rst_hdr_addr", 34'(hdr_addr), 34'(0));
    chk("rst_misc", {13'(0), err, sw_route, pkt_cnt, 2'b00}, 34'(0));
    rst_n = 1'b1;

    // 1: single HEAD_TAIL, latency
    sw_gnt = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_flit = mk(2'b11, 32'hA5A5_0023);
    @(negedge clk); in_valid = 1'b0;
    chk("t1_hdr_addr", 34'(hdr_addr), 34'(8'h23));
    chk("t1_vld_t1", 34'(out_valid), 34'(0));
    @(negedge clk);
    chk("t1_req_route", 34'(sw_req), 34'(0));
    chk("t1_vld_t2", 34'(out_valid), 34'(0));
    @(negedge clk);
    chk("t1_req_t3", 34'(sw_req), 34'(1));
    chk("t1_sw_route", 34'(sw_route), 34'(3'b001));
    chk("t1_vld_t3", 34'(out_valid), 34'(0));
    @(negedge clk);
    chk("t1_vld_t4", 34'(out_valid), 34'(1));
    chk("t1_dat", out_flit, mk(2'b11, 32'hA5A5_0023));
    @(negedge clk);
    chk("t1_req_end", 34'(sw_req), 34'(0));
    chk("t1_vld_end", 34'(out_valid), 34'(0));
    chk("t1_pkt_cnt", 34'(pkt_cnt), 34'(expc(1)));

    // 2: 4-flit packet with toggling out_ready
    pkt[0] = mk(2'b01, 32'h1111_0021); pkt[1] = mk(2'b00, 32'h2222_2222);
    pkt[2] = mk(2'b00, 32'h3333_3333); pkt[3] = mk(2'b10, 32'h4444_4444);
    run("t2", 4, 3'b000, 0, 1'b1, 1'b0);
    chk("t2_pkt_cnt", 34'(pkt_cnt), 34'(expc(2)));

    // 3: backpressure fills FIFO, 6 flits offered
    pkt[0] = mk(2'b01, 32'h0000_0032); pkt[1] = mk(2'b00, 32'h0000_0B01);
    pkt[2] = mk(2'b01, 32'h0000_0B02); pkt[3] = mk(2'b00, 32'h0000_0B03);
    pkt[4] = mk(2'b00, 32'h0000_0B04); pkt[5] = mk(2'b10, 32'h0000_0B05);
    run("t3", 6, 3'b011, 8, 1'b0, 1'b1);
    chk("t3_pkt_cnt", 34'(pkt_cnt), 34'(expc(3)));

    // 4: orphan BODY in IDLE
    @(negedge clk); in_valid = 1'b1; in_flit = mk(2'b00, 32'hDEAD_0011);
    @(negedge clk); in_valid = 1'b0;
    chk("t4_err_pre", 34'(err), 34'(0));
    @(negedge clk);
    chk("t4_err_pulse", 34'(err), 34'(1));
    chk("t4_req_pulse", 34'(sw_req), 34'(0));
    @(negedge clk);
    chk("t4_err_post", 34'(err), 34'(0));
    chk("t4_req_post", 34'(sw_req), 34'(0));
    chk("t4_vld_post", 34'(out_valid), 34'(0));
    chk("t4_pkt_cnt", 34'(pkt_cnt), 34'(expc(3)));

    // 5: reset mid-XFER
    out_ready = 1'b0;
    pkt[0] = mk(2'b01, 32'h0000_0012); pkt[1] = mk(2'b00, 32'h0000_0C01);
    pkt[2] = mk(2'b00, 32'h0000_0C02); pkt[3] = mk(2'b10, 32'h0000_0C03);
    k = 0;
    for (int c = 0; c < 30 && !out_valid; c++) begin
      @(negedge clk);
      if (k < 4) begin
        in_valid = 1'b1; in_flit = pkt[k];
        if (in_ready) k++;
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("t5_xfer_reached", 34'(out_valid), 34'(1));
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_in_ready", 34'(in_ready), 34'(1));
    chk("t5_rst_req", 34'(sw_req), 34'(0));
    chk("t5_rst_vld", 34'(out_valid), 34'(0));
    chk("t5_rst_flit", out_flit, 34'(0));
    chk("t5_rst_misc", {13'(0), err, sw_route, pkt_cnt, 2'b00}, 34'(0));
    @(negedge clk); rst_n = 1'b1;
    pkt[0] = mk(2'b11, 32'h7777_0025);
    run("t5_next", 1, 3'b001, 0, 1'b0, 1'b0);
    chk("t5_pkt_cnt", 34'(pkt_cnt), 34'(expc(1)));

    // 6: grant withheld for 10 cycles
    sw_gnt = 1'b0; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_flit = mk(2'b11, 32'h6666_0022);
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 20 && !sw_req; c++) @(negedge clk);
    chk("t6_req_seen", 34'(sw_req), 34'(1));
    for (int i = 0; i < 10; i++) begin
      chk("t6_req_hold", 34'(sw_req), 34'(1));
      chk("t6_no_vld", 34'(out_valid), 34'(0));
      @(negedge clk);
    end
    sw_gnt = 1'b1;
    chk("t6_grant_cycle_vld", 34'(out_valid), 34'(0));
    @(negedge clk);
    chk("t6_vld", 34'(out_valid), 34'(1));
    chk("t6_dat", out_flit, mk(2'b11, 32'h6666_0022));
    chk("t6_sw_route", 34'(sw_route), 34'(3'b100));
    @(negedge clk);
    chk("t6_req_end", 34'(sw_req), 34'(0));
    chk("t6_pkt_cnt", 34'(pkt_cnt), 34'(expc(2)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
